angle_sensor_poller: RTL and testbench
======================================

// Module: angle_sensor_poller
// PURPOSE
//  SPI master polling up to NUM_SENSORS AS5048-type 14-bit magnetic angle encoders on the shared
//  angle_* conduit (miso/mosi/sck/ss_n_o) of the forearm controller. Round-robin reads each enabled
//  sensor, parity-checks replies and publishes per-sensor angle/error registers.
//  Sits directly upstream of myocontrol, which consumes the angles for joint control and Avalon readback.
// PARAMETERS
//  NUM_SENSORS  3    sensors on the bus, one active-low select each
//  CLK_DIV      8    clk_clk cycles per sck half-period (>=2)
//  GAP_CYCLES   50   ss_n high time between frames, in clk_clk cycles (>=1)
// PORTS
//  clk_clk          in   1               system clock
//  reset_reset_n    in   1               synchronous active-low reset
//  enable           in   1               1 = run polling loop
//  sensor_mask      in   NUM_SENSORS     1 = sensor i is polled
//  angle_miso       in   1               SPI data from sensors
//  angle_mosi       out  1               SPI data to sensors
//  angle_sck        out  1               SPI clock, CPOL=0
//  angle_ss_n_o     out  NUM_SENSORS     active-low selects
//  angles           out  14*NUM_SENSORS  angle of sensor i at [14i+13:14i]
//  error_flags      out  NUM_SENSORS     1 = last reply of sensor i had parity or EF error
//  sample_valid     out  1               1-cycle pulse when a register is updated
//  sample_index     out  2               sensor index of the sample_valid update
//  frame_count      out  32              completed frames, wraps at 2^32
// BEHAVIOUR
//  - Clock and reset: one clock, clk_clk. Reset is synchronous and active-low (reset_reset_n).
//  - Reset values: ss_n all 1, sck 0, mosi 0, angles 0, error_flags 0, sample_valid 0,
//    sample_index 0, frame_count 0. The per-sensor primed bits clear and the FSM goes to IDLE.
//  - A reset mid-frame aborts the frame. Selects go high on the next edge.
//  - SPI mode 1: mosi changes on the sck rising edge; miso is sampled on the falling edge.
//    16 bits per frame, MSB first. Command is always 0xFFFF (read 0x3FFF, R=1, even parity).
//  - FSM states:
//    IDLE -> SELECT when enable=1 and mask!=0, starting at the lowest enabled index >= ptr.
//    SELECT: ss_n[i]=0, wait CLK_DIV cycles, then -> SHIFT.
//    SHIFT: 16 sck periods, then -> HOLD.
//    HOLD: CLK_DIV cycles with sck=0, then ss_n high -> GAP.
//    GAP: wait GAP_CYCLES, then -> NEXT.
//    NEXT: advance ptr to the next enabled index (wrapping past NUM_SENSORS-1). Go to SELECT if
//    enable=1 and mask!=0, else IDLE.
//  - enable and mask changes take effect at NEXT only. An active frame always completes.
//  - A mask bit cleared mid-frame still lets that sensor's result commit.
//  - Replies are pipelined: a reply carries the result of the previous command.
//    The first frame after reset only sets primed[i]; no update and no sample_valid.
//  - Commit on a primed frame, in the cycle after HOLD ends:
//    - rx = received word. perr = ^rx (odd parity = error). ef = rx[14].
//    - perr=0 and ef=0: angles[i] <= rx[13:0], error_flags[i] <= 0.
//    - Otherwise angles[i] is held and error_flags[i] <= 1.
//    - sample_valid=1 and sample_index=i for exactly that cycle, in both cases.
//  - frame_count increments on every completed frame, including unprimed frames.
//  - At most one select is low at any time.
// CONFIGURATION
//  ANGLE_UNWRAP_EN defined:
//  - Adds output turns [16*NUM_SENSORS-1:0], signed 16-bit turn count per sensor, reset 0.
//  - On a good commit, d = new - old (14-bit):
//    - d < -8192: turns+1.
//    - d > 8192: turns-1.
//    - |d| == 8192: no change.
//  - Turns does not update on the first good sample after reset or after an error.
//  - Turns wraps at 16 bits.
//  ANGLE_UNWRAP_EN undefined: no turns port and no unwrap logic.
// TESTING
//  1. Reset with mask=3'b111, enable=1, model replies 0x3FFF.
//     -> First 3 frames give no sample_valid. Frame 4 gives angles[0]=0x3FFF, sample_index=0.
//  2. Sensor 1 replies 0x1234 (parity even), with timing checks.
//     -> angles[1]=0x1234, error_flags[1]=0.
//     -> sck period = 2*CLK_DIV clocks; ss_n gap >= GAP_CYCLES.
//  3. Sensor 2 replies 0x1235 (odd parity), then 0x4000 (EF set).
//     -> angles[2] held, error_flags[2]=1 both times.
//     -> A following good 0x0010 clears the error.
//  4. mask=3'b101 -> select sequence 0,2,0,2.
//     mask=0 mid-frame -> the current frame completes, then IDLE.
//     Selects stay all 1 and frame_count is frozen.
//  5. Assert reset_reset_n=0 at bit 7 of a frame.
//     -> Next edge: ss_n=111, sck=0, frame_count=0, primed cleared.
//  6. (ANGLE_UNWRAP_EN) Sensor 0 sequence 0x3F00 -> 0x0010 -> 0x3FF0 -> 0x2000 -> 0x0000.
//     -> turns 0 -> 1 -> 0 -> 0 -> 0 (the last step is |d|=8192, no change).

Source files
------------

// File: rtl/angle_sensor_poller.sv
// angle_sensor_poller
// SPI mode-1 master that round-robins up to NUM_SENSORS AS5048-style 14-bit
// angle encoders on a shared bus. Every frame sends the read command 0xFFFF.
// Each reply is parity and EF checked, and the per-sensor angle and error
// registers are then updated.
// Replies are pipelined, so a sensor's first frame after reset only primes it.
//
// Optional build macro: ANGLE_UNWRAP_EN adds the 'turns' output. It holds a
// signed 16-bit turn counter per sensor, updated on good samples.
//
// Ports
//   clk_clk        system clock
//   reset_reset_n  synchronous active-low reset
//   enable         run the polling loop (sampled between frames)
//   sensor_mask    per-sensor poll enable (sampled between frames)
//   angle_miso     SPI data from sensors
//   angle_mosi     SPI data to sensors
//   angle_sck      SPI clock, idles low
//   angle_ss_n_o   active-low selects, at most one low
//   angles         14-bit angle of sensor i at [14i+13:14i]
//   error_flags    last reply of sensor i failed parity or had EF set
//   sample_valid   one-cycle pulse on a register commit
//   sample_index   sensor index of that commit
//   frame_count    completed frames, wrapping
//   turns          (ANGLE_UNWRAP_EN only) signed turn count per sensor
//
// state  | meaning
// IDLE   | bus quiet, waiting for enable with a non-empty mask
// SELECT | select low, setup time before the first sck edge
// SHIFT  | 16 sck periods; mosi updates on rise, miso sampled on fall
// HOLD   | sck low, select still low; commit on exit
// GAP    | select high, inter-frame spacing
// NEXT   | advance pointer, resample enable/mask
module angle_sensor_poller #(
    parameter int NUM_SENSORS = 3,
    parameter int CLK_DIV     = 8,
    parameter int GAP_CYCLES  = 50
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        enable,
    input  logic [NUM_SENSORS-1:0]      sensor_mask,
    input  logic                        angle_miso,
    output logic                        angle_mosi,
    output logic                        angle_sck,
    output logic [NUM_SENSORS-1:0]      angle_ss_n_o,
    output logic [14*NUM_SENSORS-1:0]   angles,
    output logic [NUM_SENSORS-1:0]      error_flags,
    output logic                        sample_valid,
    output logic [1:0]                  sample_index,
    output logic [31:0]                 frame_count
`ifdef ANGLE_UNWRAP_EN
    ,
    output logic [16*NUM_SENSORS-1:0]   turns
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;

    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    logic [2:0]             state;
    logic [1:0]             ptr;
    logic [15:0]            cnt;
    logic [3:0]             bit_cnt;
    logic [15:0]            rx;
    logic [NUM_SENSORS-1:0] primed;

    logic                   go;
    logic                   hold_done;
    logic                   cur_primed;
    logic                   good;
    logic [1:0]             first_idx;
    logic [1:0]             next_idx;

    function automatic logic [1:0] inc_idx(input logic [1:0] p);
        return (p == 2'(NUM_SENSORS - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Lowest enabled index at or after 'start', wrapping; returns 'start' when the mask is empty.
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [NUM_SENSORS-1:0] m);
        logic [1:0] cand;
        logic [1:0] r;
        logic       found;
        cand  = start;
        r     = start;
        found = 1'b0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (!found && m[i] && cand == 2'(i)) begin
                    r     = cand;
                    found = 1'b1;
                end
            end
            cand = inc_idx(cand);
        end
        return r;
    endfunction

    function automatic logic [NUM_SENSORS-1:0] sel_n(input logic [1:0] p);
        logic [NUM_SENSORS-1:0] s;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            s[i] = (2'(i) != p);
        end
        return s;
    endfunction

    always_comb begin
        go         = enable && (sensor_mask != '0);
        hold_done  = (state == ST_HOLD) && (cnt == 16'd0);
        good       = ~(^rx) & ~rx[14];
        first_idx  = pick(ptr, sensor_mask);
        next_idx   = pick(inc_idx(ptr), sensor_mask);
        cur_primed = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (ptr == 2'(i)) begin
                cur_primed = primed[i];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state        <= ST_IDLE;
            ptr          <= 2'd0;
            cnt          <= 16'd0;
            bit_cnt      <= 4'd0;
            rx           <= 16'd0;
            primed       <= '0;
            angle_sck    <= 1'b0;
            angle_mosi   <= 1'b0;
            angle_ss_n_o <= '1;
            angles       <= '0;
            error_flags  <= '0;
            sample_valid <= 1'b0;
            sample_index <= 2'd0;
            frame_count  <= 32'd0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        ptr          <= first_idx;
                        angle_ss_n_o <= sel_n(first_idx);
                        cnt          <= DIV_LOAD;
                        state        <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (cnt == 16'd0) begin
                        cnt     <= DIV_LOAD;
                        bit_cnt <= 4'd15;
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == 16'd0) begin
                        cnt       <= DIV_LOAD;
                        angle_sck <= ~angle_sck;
                        if (!angle_sck) begin
                            angle_mosi <= 1'b1;
                        end else begin
                            rx <= {rx[14:0], angle_miso};
                            if (bit_cnt == 4'd0) begin
                                state <= ST_HOLD;
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                            end
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == 16'd0) begin
                        angle_ss_n_o <= '1;
                        angle_mosi   <= 1'b0;
                        cnt          <= GAP_LOAD;
                        frame_count  <= frame_count + 32'd1;
                        state        <= ST_GAP;
                        for (int i = 0; i < NUM_SENSORS; i++) begin
                            if (ptr == 2'(i)) begin
                                primed[i] <= 1'b1;
                                if (primed[i]) begin
                                    if (good) begin
                                        angles[14*i +: 14] <= rx[13:0];
                                        error_flags[i]     <= 1'b0;
                                    end else begin
                                        error_flags[i]     <= 1'b1;
                                    end
                                end
                            end
                        end
                        if (cur_primed) begin
                            sample_valid <= 1'b1;
                            sample_index <= ptr;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 16'd0) begin
                        state <= ST_NEXT;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_NEXT: begin
                    ptr <= next_idx;
                    if (go) begin
                        angle_ss_n_o <= sel_n(next_idx);
                        cnt          <= DIV_LOAD;
                        state        <= ST_SELECT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ANGLE_UNWRAP_EN
    // 'tracking' marks that the stored angle is a valid reference for unwrapping.
    logic [NUM_SENSORS-1:0] tracking;
    logic [13:0]            old_angle;
    logic signed [14:0]     diff;

    always_comb begin
        old_angle = 14'd0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (ptr == 2'(i)) begin
                old_angle = angles[14*i +: 14];
            end
        end
        // 15-bit difference so that a jump across the 0/16383 seam is visible beyond +-8192.
        diff = {1'b0, rx[13:0]} - {1'b0, old_angle};
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            turns    <= '0;
            tracking <= '0;
        end else if (hold_done && cur_primed) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (ptr == 2'(i)) begin
                    if (!good) begin
                        tracking[i] <= 1'b0;
                    end else begin
                        tracking[i] <= 1'b1;
                        if (tracking[i]) begin
                            if (diff < -15'sd8192) begin
                                turns[16*i +: 16] <= turns[16*i +: 16] + 16'd1;
                            end else if (diff > 15'sd8192) begin
                                turns[16*i +: 16] <= turns[16*i +: 16] - 16'd1;
                            end
                        end
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_angle_sensor_poller.sv
// Directed bench for angle_sensor_poller with a behavioural SPI slave and a
// scoreboard. Each frame start pushes the expected commit, and the frame end pops and compares it.
module tb_angle_sensor_poller;
    localparam int NS           = 3;
    localparam int CD           = 4;
    localparam int GP           = 10;
    localparam int FRAME_BUDGET = 1000;

    logic                 clk_clk = 1'b0;
    logic                 reset_reset_n;
    logic                 enable;
    logic [NS-1:0]        sensor_mask;
    logic                 angle_miso;
    logic                 angle_mosi;
    logic                 angle_sck;
    logic [NS-1:0]        angle_ss_n_o;
    logic [14*NS-1:0]     angles;
    logic [NS-1:0]        error_flags;
    logic                 sample_valid;
    logic [1:0]           sample_index;
    logic [31:0]          frame_count;
`ifdef ANGLE_UNWRAP_EN
    logic [16*NS-1:0]     turns;
`endif

    always #5 clk_clk = ~clk_clk;

    angle_sensor_poller #(.NUM_SENSORS(NS), .CLK_DIV(CD), .GAP_CYCLES(GP)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (enable),
        .sensor_mask   (sensor_mask),
        .angle_miso    (angle_miso),
        .angle_mosi    (angle_mosi),
        .angle_sck     (angle_sck),
        .angle_ss_n_o  (angle_ss_n_o),
        .angles        (angles),
        .error_flags   (error_flags),
        .sample_valid  (sample_valid),
        .sample_index  (sample_index),
        .frame_count   (frame_count)
`ifdef ANGLE_UNWRAP_EN
        ,
        .turns         (turns)
`endif
    );

    typedef struct {
        int          idx;
        logic [13:0] ang;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          seq_log[$];
    logic [15:0] reply [NS];

    int          total = 0;
    int          bad   = 0;

    int          cyc = 0;
    int          exp_frames = 0;
    int          frames_seen = 0;
    int          frames_started = 0;
    int          sck_rises = 0;
    int          n_samples = 0;
    int          last_idx = -1;
    int          rise_cyc = 0;
    int          last_sck = 0;
    logic        have_rise = 1'b0;
    logic        have_sck = 1'b0;
    logic [NS-1:0] prev_ss = '1;
    logic        prev_sck = 1'b0;
    logic [15:0] sh = 16'h0;
    logic [NS-1:0] m_primed = '0;
    logic [13:0] m_ang [NS];
    logic        m_err [NS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reply word with even parity over all 16 bits.
    function automatic logic [15:0] enc(input logic [14:0] payload);
        return {^payload, payload};
    endfunction

    function automatic logic [13:0] angle_of(input logic [14*NS-1:0] a, input int idx);
        logic [14*NS-1:0] t;
        t = a >> (14 * idx);
        return t[13:0];
    endfunction

    task automatic tick();
        int            nlow;
        int            idx;
        logic          rose;
        logic          fell;
        exp_t          e;
        logic [NS-1:0] tf;
        @(negedge clk_clk);
        cyc++;
        if (!reset_reset_n) begin
            sb.delete();
            m_primed   = '0;
            exp_frames = 0;
            have_rise  = 1'b0;
            have_sck   = 1'b0;
            sh         = 16'h0;
            angle_miso = 1'b0;
            for (int i = 0; i < NS; i++) begin
                m_ang[i] = 14'h0;
                m_err[i] = 1'b0;
            end
        end else begin
            fell = (prev_ss == '1) && (angle_ss_n_o != '1);
            rose = (prev_ss != '1) && (angle_ss_n_o == '1);
            if (fell) begin
                nlow = 0;
                idx  = 0;
                for (int i = 0; i < NS; i++) begin
                    if (!angle_ss_n_o[i]) begin
                        nlow++;
                        idx = i;
                    end
                end
                check("one_select_low", nlow, 1);
                if (have_rise) check("ss_gap_min", 32'((cyc - rise_cyc) >= GP), 1);
                seq_log.push_back(idx);
                frames_started++;
                sh       = reply[idx];
                have_sck = 1'b0;
                if (m_primed[idx]) begin
                    if ((^sh) == 1'b0 && !sh[14]) begin
                        m_ang[idx] = sh[13:0];
                        m_err[idx] = 1'b0;
                    end else begin
                        m_err[idx] = 1'b1;
                    end
                    e.idx = idx;
                    e.ang = m_ang[idx];
                    e.err = m_err[idx];
                    sb.push_back(e);
                end
                m_primed[idx] = 1'b1;
            end
            if (angle_sck && !prev_sck) begin
                angle_miso = sh[15];
                sh = {sh[14:0], 1'b0};
                check("mosi_cmd_bit", 32'(angle_mosi), 1);
                if (have_sck) check("sck_period", cyc - last_sck, 2 * CD);
                have_sck = 1'b1;
                last_sck = cyc;
                sck_rises++;
            end
            if (rose) begin
                exp_frames++;
                frames_seen++;
                rise_cyc  = cyc;
                have_rise = 1'b1;
                check("frame_count", frame_count, exp_frames);
                check("sample_valid_at_frame_end", 32'(sample_valid), 32'(sb.size() > 0));
                if (sample_valid) begin
                    n_samples++;
                    last_idx = int'(sample_index);
                end
                if (sb.size() > 0) begin
                    e  = sb.pop_front();
                    tf = error_flags >> e.idx;
                    check("sample_index", 32'(sample_index), e.idx);
                    check("angle_commit", 32'(angle_of(angles, e.idx)), 32'(e.ang));
                    check("error_flag_commit", 32'(tf[0]), 32'(e.err));
                end
            end else if (sample_valid) begin
                n_samples++;
                check("stray_sample_valid", 32'(sample_valid), 0);
            end
        end
        prev_ss  = angle_ss_n_o;
        prev_sck = angle_sck;
    endtask

    task automatic run_frames(input int n);
        int target;
        int budget;
        target = frames_seen + n;
        budget = n * FRAME_BUDGET;
        while (frames_seen < target && budget > 0) begin
            tick();
            budget--;
        end
        if (frames_seen < target) check("frame_timeout", frames_seen, target);
    endtask

    task automatic wait_fall();
        int target;
        int budget;
        target = frames_started + 1;
        budget = FRAME_BUDGET;
        while (frames_started < target && budget > 0) begin
            tick();
            budget--;
        end
        if (frames_started < target) check("select_timeout", frames_started, target);
    endtask

    task automatic wait_rises(input int n);
        int target;
        int budget;
        target = sck_rises + n;
        budget = FRAME_BUDGET;
        while (sck_rises < target && budget > 0) begin
            tick();
            budget--;
        end
        if (sck_rises < target) check("sck_timeout", sck_rises, target);
    endtask

    initial begin
        int base;
        int ns0;
        int frozen;
        int low_cycles;
        int exp_seq [4];

        reset_reset_n = 1'b0;
        enable        = 1'b1;
        sensor_mask   = 3'b111;
        angle_miso    = 1'b0;
        for (int i = 0; i < NS; i++) reply[i] = enc(15'h3FFF);
        repeat (3) tick();

        check("rst_ss_n", 32'(angle_ss_n_o), 32'h7);
        check("rst_sck", 32'(angle_sck), 0);
        check("rst_mosi", 32'(angle_mosi), 0);
        check("rst_angles", 32'(angles[31:0]), 0);
        check("rst_angles_hi", 32'(angles[41:32]), 0);
        check("rst_error_flags", 32'(error_flags), 0);
        check("rst_sample_valid", 32'(sample_valid), 0);
        check("rst_sample_index", 32'(sample_index), 0);
        check("rst_frame_count", frame_count, 0);
        reset_reset_n = 1'b1;

        // Priming: one silent frame per sensor, then sensor 0 commits.
        run_frames(3);
        check("no_sample_unprimed", n_samples, 0);
        run_frames(1);
        check("first_sample_index", last_idx, 0);
        check("first_angle0", 32'(angle_of(angles, 0)), 32'h3FFF);

        // Good reply on sensor 1.
        reply[1] = enc(15'h1234);
        run_frames(3);
        check("angle1_1234", 32'(angle_of(angles, 1)), 32'h1234);
        check("err1_clear", 32'(error_flags[1]), 0);

        // Sensor 2: parity error, then EF, then recovery.
        reply[2] = enc(15'h1235) ^ 16'h8000;
        run_frames(3);
        check("angle2_held_parity", 32'(angle_of(angles, 2)), 32'h3FFF);
        check("err2_parity", 32'(error_flags[2]), 1);
        reply[2] = enc(15'h4000);
        run_frames(3);
        check("angle2_held_ef", 32'(angle_of(angles, 2)), 32'h3FFF);
        check("err2_ef", 32'(error_flags[2]), 1);
        reply[2] = enc(15'h0010);
        run_frames(3);
        check("angle2_0010", 32'(angle_of(angles, 2)), 32'h0010);
        check("err2_recovered", 32'(error_flags[2]), 0);

        // Mask 101: sensor 1 skipped. Frame 16 was sensor 0, so 2,0,2,0 follows.
        sensor_mask = 3'b101;
        base = seq_log.size();
        run_frames(4);
        exp_seq = '{2, 0, 2, 0};
        for (int k = 0; k < 4; k++) begin
            check("mask101_seq", seq_log[base + k], exp_seq[k]);
        end

        // Mask cleared mid-frame: frame finishes, then bus stays quiet.
        wait_fall();
        repeat (20) tick();
        sensor_mask = 3'b000;
        run_frames(1);
        frozen = exp_frames;
        base = seq_log.size();
        low_cycles = 0;
        repeat (600) begin
            tick();
            if (angle_ss_n_o != '1) low_cycles++;
        end
        check("idle_ss_high", low_cycles, 0);
        check("idle_no_new_frame", seq_log.size(), base);
        check("idle_frame_count_frozen", frame_count, frozen);

        // Reset at bit 7 of a frame.
        sensor_mask = 3'b111;
        wait_fall();
        wait_rises(7);
        reset_reset_n = 1'b0;
        tick();
        check("midrst_ss_n", 32'(angle_ss_n_o), 32'h7);
        check("midrst_sck", 32'(angle_sck), 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_angles", 32'(angle_of(angles, 0)), 0);
        reset_reset_n = 1'b1;
        ns0 = n_samples;
        run_frames(3);
        check("reprime_no_sample", n_samples, ns0);
        run_frames(1);
        check("reprime_sample_index", last_idx, 0);
        check("reprime_angle0", 32'(angle_of(angles, 0)), 32'h3FFF);

`ifdef ANGLE_UNWRAP_EN
        sensor_mask = 3'b001;
        reply[0] = enc(15'h3F00);
        run_frames(1);
        check("turns_3f00", 32'(turns[15:0]), 0);
        reply[0] = enc(15'h0010);
        run_frames(1);
        check("turns_0010", 32'(turns[15:0]), 1);
        reply[0] = enc(15'h3FF0);
        run_frames(1);
        check("turns_3ff0", 32'(turns[15:0]), 0);
        reply[0] = enc(15'h2000);
        run_frames(1);
        check("turns_2000", 32'(turns[15:0]), 0);
        reply[0] = enc(15'h0000);
        run_frames(1);
        check("turns_0000_half", 32'(turns[15:0]), 0);
        reply[0] = enc(15'h3000);
        run_frames(1);
        check("turns_3000_neg", 32'(turns[15:0]), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
